// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between ICache miss path and DCache miss/writeback path.
// Define MEM_ARB_RR_EN for round-robin priority; default build gives DC fixed priority over IC.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t state;
  logic   owner_dc;
  logic   prio_dc;
  logic   grant_dc;
  logic   grant_ic;

`ifdef MEM_ARB_RR_EN
  logic last_owner;  // 1 = DC was granted last
  assign prio_dc = ~last_owner;
`else
  assign prio_dc = 1'b1;
`endif

  assign grant_dc     = (state == IDLE) & dc_req_valid & (~ic_req_valid | prio_dc);
  assign grant_ic     = (state == IDLE) & ic_req_valid & ~grant_dc;
  assign dc_req_ready = grant_dc;
  assign ic_req_ready = grant_ic;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_dc      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner    <= 1'b0;
`endif
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      if (mem_resp_valid && state != WAIT_RESP) err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_dc || grant_ic) begin
            owner_dc      <= grant_dc;
            mem_req_rw    <= grant_dc & dc_req_rw;
            mem_req_addr  <= grant_dc ? dc_req_addr : ic_req_addr;
            mem_req_wdata <= grant_dc ? dc_req_wdata : '0;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_owner    <= grant_dc;
`endif
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            // Writes are acknowledged at issue; only DC can own a write.
            if (mem_req_rw) begin
              state         <= IDLE;
              busy          <= 1'b0;
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= '0;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_dc) begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= mem_resp_data;
            end else begin
              ic_resp_valid <= 1'b1;
              ic_resp_data  <= mem_resp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_wdata;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DATA_W-1:0] D_IC   = 128'hDEAD_0001_0002_0003_0004_0005_0006_BEEF;
  localparam logic [DATA_W-1:0] D_A    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DATA_W-1:0] D_B    = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0; ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_rw = 0;
    dc_req_addr = '0; dc_req_wdata = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, err, mem_req_valid, ic_resp_valid, dc_resp_valid} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, err, mem_req_valid, ic_resp_valid, dc_resp_valid}); end
    n_cmp++; if ({mem_req_addr, mem_req_wdata, ic_resp_data, dc_resp_data} !== '0) begin n_bad++;
      $display("FAIL reset_data: addr %h wdata %h icd %h dcd %h want 0", mem_req_addr, mem_req_wdata, ic_resp_data, dc_resp_data); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ic_req_ready, dc_req_ready, busy} !== 3'b0) begin n_bad++;
      $display("FAIL reset_idle: got %b want 000", {ic_req_ready, dc_req_ready, busy}); end
  endtask

  task automatic test_ic_read;
    @(negedge clk); ic_req_valid = 1; ic_req_addr = 32'h0000_1000; mem_req_ready = 1; #1;
    n_cmp++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin n_bad++;
      $display("FAIL ic_grant: got %b want 10", {ic_req_ready, dc_req_ready}); end
    @(negedge clk); ic_req_valid = 0; ic_req_addr = '0;
    n_cmp++; if ({mem_req_valid, mem_req_rw, busy} !== 3'b101 || mem_req_addr !== 32'h1000 || mem_req_wdata !== '0) begin n_bad++;
      $display("FAIL ic_issue: v/rw/busy %b addr %h wdata %h want 101 1000 0", {mem_req_valid, mem_req_rw, busy}, mem_req_addr, mem_req_wdata); end
    @(negedge clk);
    n_cmp++; if ({mem_req_valid, busy} !== 2'b01) begin n_bad++;
      $display("FAIL ic_wait: v/busy %b want 01", {mem_req_valid, busy}); end
    @(negedge clk);
    n_cmp++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin n_bad++;
      $display("FAIL ic_early_resp: got %b want 00", {ic_resp_valid, dc_resp_valid}); end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_IC;
    @(negedge clk); mem_resp_valid = 0; mem_resp_data = '0;
    n_cmp++; if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b100 || ic_resp_data !== D_IC) begin n_bad++;
      $display("FAIL ic_resp: v/dv/busy %b data %h want 100 %h", {ic_resp_valid, dc_resp_valid, busy}, ic_resp_data, D_IC); end
    @(negedge clk);
    n_cmp++; if (ic_resp_valid !== 1'b0 || ic_resp_data !== D_IC) begin n_bad++;
      $display("FAIL ic_pulse_hold: v %b data %h want 0 %h", ic_resp_valid, ic_resp_data, D_IC); end
  endtask

  task automatic test_dc_write_bp;
    @(negedge clk); dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h2000; dc_req_wdata = 128'h1234;
    mem_req_ready = 0; #1;
    n_cmp++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin n_bad++;
      $display("FAIL dcw_grant: got %b want 01", {ic_req_ready, dc_req_ready}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_wdata = '0; end
      n_cmp++; if ({mem_req_valid, mem_req_rw} !== 2'b11 || mem_req_addr !== 32'h2000 || mem_req_wdata !== 128'h1234) begin n_bad++;
        $display("FAIL dcw_hold%0d: v/rw %b addr %h wdata %h want 11 2000 1234", i, {mem_req_valid, mem_req_rw}, mem_req_addr, mem_req_wdata); end
      if (i == 4) mem_req_ready = 1;
    end
    @(negedge clk); mem_req_ready = 0;
    n_cmp++; if ({mem_req_valid, dc_resp_valid, ic_resp_valid, busy} !== 4'b0100 || dc_resp_data !== '0) begin n_bad++;
      $display("FAIL dcw_ack: v/dv/iv/busy %b data %h want 0100 0", {mem_req_valid, dc_resp_valid, ic_resp_valid, busy}, dc_resp_data); end
    @(negedge clk);
    n_cmp++; if ({dc_resp_valid, busy} !== 2'b00) begin n_bad++;
      $display("FAIL dcw_after: dv/busy %b want 00", {dc_resp_valid, busy}); end
  endtask

  task automatic test_simultaneous;
    logic first_dc;
    logic [ADDR_W-1:0] wa, la;
    first_dc = !RR;
    wa = first_dc ? 32'h4000 : 32'h3000;
    la = first_dc ? 32'h3000 : 32'h4000;
    @(negedge clk); ic_req_valid = 1; ic_req_addr = 32'h3000; dc_req_valid = 1; dc_req_rw = 0;
    dc_req_addr = 32'h4000; mem_req_ready = 1; #1;
    n_cmp++; if ({dc_req_ready, ic_req_ready} !== {first_dc, !first_dc}) begin n_bad++;
      $display("FAIL sim_first_grant: dc/ic %b want %b", {dc_req_ready, ic_req_ready}, {first_dc, !first_dc}); end
    @(negedge clk);
    if (first_dc) dc_req_valid = 0; else ic_req_valid = 0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== wa || {ic_req_ready, dc_req_ready} !== 2'b00) begin n_bad++;
      $display("FAIL sim_first_issue: v %b addr %h rdy %b want 1 %h 00", mem_req_valid, mem_req_addr, {ic_req_ready, dc_req_ready}, wa); end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_A;
    @(negedge clk); mem_resp_valid = 0; #1;
    n_cmp++; if ({dc_resp_valid, ic_resp_valid} !== {first_dc, !first_dc} || (first_dc ? dc_resp_data : ic_resp_data) !== D_A) begin n_bad++;
      $display("FAIL sim_first_resp: dv/iv %b want %b", {dc_resp_valid, ic_resp_valid}, {first_dc, !first_dc}); end
    n_cmp++; if ({dc_req_ready, ic_req_ready} !== {!first_dc, first_dc}) begin n_bad++;
      $display("FAIL sim_second_grant: dc/ic %b want %b", {dc_req_ready, ic_req_ready}, {!first_dc, first_dc}); end
    @(negedge clk); ic_req_valid = 0; dc_req_valid = 0;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== la) begin n_bad++;
      $display("FAIL sim_second_issue: v %b addr %h want 1 %h", mem_req_valid, mem_req_addr, la); end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_B;
    @(negedge clk); mem_resp_valid = 0;
    n_cmp++; if ({dc_resp_valid, ic_resp_valid} !== {!first_dc, first_dc} || (first_dc ? ic_resp_data : dc_resp_data) !== D_B) begin n_bad++;
      $display("FAIL sim_second_resp: dv/iv %b want %b", {dc_resp_valid, ic_resp_valid}, {!first_dc, first_dc}); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h5000; mem_req_ready = 1;
    @(negedge clk); dc_req_valid = 0;
    @(negedge clk); ic_req_valid = 1; ic_req_addr = 32'h6000; mem_resp_valid = 1; mem_resp_data = D_B; #1;
    n_cmp++; if (ic_req_ready !== 1'b0) begin n_bad++;
      $display("FAIL b2b_busy_ready: got %b want 0", ic_req_ready); end
    @(negedge clk); mem_resp_valid = 0; #1;
    n_cmp++; if ({dc_resp_valid, ic_req_ready, ic_resp_valid} !== 3'b110 || dc_resp_data !== D_B) begin n_bad++;
      $display("FAIL b2b_overlap: dv/irdy/iv %b data %h want 110 %h", {dc_resp_valid, ic_req_ready, ic_resp_valid}, dc_resp_data, D_B); end
    @(negedge clk); ic_req_valid = 0;
    n_cmp++; if ({mem_req_valid, dc_resp_valid} !== 2'b10 || mem_req_addr !== 32'h6000) begin n_bad++;
      $display("FAIL b2b_ic_issue: v/dv %b addr %h want 10 6000", {mem_req_valid, dc_resp_valid}, mem_req_addr); end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_A;
    @(negedge clk); mem_resp_valid = 0;
    n_cmp++; if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== D_A) begin n_bad++;
      $display("FAIL b2b_ic_resp: iv/dv %b data %h want 10 %h", {ic_resp_valid, dc_resp_valid}, ic_resp_data, D_A); end
  endtask

  task automatic test_spurious;
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_B;
    @(negedge clk); mem_resp_valid = 0;
    n_cmp++; if ({err, ic_resp_valid, dc_resp_valid, busy} !== 4'b1000) begin n_bad++;
      $display("FAIL spur_err: err/iv/dv/busy %b want 1000", {err, ic_resp_valid, dc_resp_valid, busy}); end
    ic_req_valid = 1; ic_req_addr = 32'h7000; mem_req_ready = 1;
    @(negedge clk); ic_req_valid = 0;
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D_IC;
    @(negedge clk); mem_resp_valid = 0;
    n_cmp++; if ({ic_resp_valid, err} !== 2'b11 || ic_resp_data !== D_IC) begin n_bad++;
      $display("FAIL spur_next_txn: iv/err %b data %h want 11 %h", {ic_resp_valid, err}, ic_resp_data, D_IC); end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk); ic_req_valid = 1; ic_req_addr = 32'h8000; mem_req_ready = 1;
    @(negedge clk); ic_req_valid = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    #2 reset_n = 0; #1;
    n_cmp++; if ({busy, err, mem_req_valid, mem_req_rw, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready} !== 8'b0 ||
                 {mem_req_addr, mem_req_wdata, ic_resp_data, dc_resp_data} !== '0) begin n_bad++;
      $display("FAIL rst_async: ctrl %b want 00000000", {busy, err, mem_req_valid, mem_req_rw, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready}); end
    @(negedge clk); reset_n = 1; mem_resp_valid = 1; mem_resp_data = D_A;
    @(negedge clk); mem_resp_valid = 0;
    n_cmp++; if ({err, ic_resp_valid, dc_resp_valid} !== 3'b100 || ic_resp_data !== '0) begin n_bad++;
      $display("FAIL rst_late_resp: err/iv/dv %b icd %h want 100 0", {err, ic_resp_valid, dc_resp_valid}, ic_resp_data); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rst_err_sticky: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write_bp();
    test_simultaneous();
    test_back_to_back();
    test_spurious();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the Riscv151 pipeline.
- Holds at most one memory transaction in flight. It latches the winning request, drives it to memory under a valid/ready handshake, and steers the read response back to the owner.
- Sits between the two caches and the memory model or DRAM interface. The caches stall the pipeline while their own request is pending.

Parameters:
- ADDR_W, 32, width of request address in bits.
- DATA_W, 128, width of one cache line transferred per transaction.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset; asynchronous assertion, active-low
- ic_req_valid  in  1  ICache read miss request
- ic_req_ready  out  1  ICache request accepted this cycle
- ic_req_addr  in  ADDR_W  ICache line address
- ic_resp_valid  out  1  one-cycle pulse; ic_resp_data valid
- ic_resp_data  out  DATA_W  returned line
- dc_req_valid  in  1  DCache request
- dc_req_ready  out  1  DCache request accepted this cycle
- dc_req_rw  in  1  1 = write (writeback), 0 = read
- dc_req_addr  in  ADDR_W  DCache line address
- dc_req_wdata  in  DATA_W  writeback data
- dc_resp_valid  out  1  one-cycle pulse; read data, or write ack
- dc_resp_data  out  DATA_W  returned line (0 for write ack)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  latched rw
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wdata  out  DATA_W  latched write data
- mem_resp_valid  in  1  memory read data valid
- mem_resp_data  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- err  out  1  sticky: mem_resp_valid seen outside WAIT_RESP

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset asserted mid-transaction abandons it; a late mem_resp_valid after reset_n deasserts sets err.
- States:
  - IDLE: arbitrate among valid requesters. Ready goes high only to the winner, computed combinationally from state and valid inputs. The loser's ready is 0.
  - On an accept edge (valid & ready), latch owner, rw, addr and wdata (wdata forced 0 when owner=IC). Then go to ISSUE.
  - ISSUE: mem_req_valid=1. Fields are held stable until mem_req_ready=1.
  - At the ISSUE handshake edge, a read goes to WAIT_RESP. A DC write goes to IDLE and pulses dc_resp_valid the next cycle with dc_resp_data=0.
  - WAIT_RESP: on the mem_resp_valid edge, register the data into the owner's resp_data, pulse the owner's resp_valid for exactly one cycle, and go to IDLE. The non-owner's resp_valid stays 0.
- Latency:
  - Accept edge k; mem_req_valid high from cycle k+1.
  - If mem_req_ready is already 1 in cycle k+1, the request is issued at edge k+1.
  - Response: resp_valid high one cycle after the cycle with mem_resp_valid.
  - Minimum read turnaround: a new accept is possible in the same cycle resp_valid is high, because state is IDLE then.
- Priority (default): DC beats IC when both are valid in IDLE.
- mem_req_ready while not in ISSUE: ignored.
- mem_resp_valid in IDLE or ISSUE: ignored for data, and sets err. err clears only on reset.
- resp_data registers hold their last value between pulses.
- No requester is expected to drop valid before ready. If one does, its request is never accepted, with no side effects.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Priority is round-robin via a 1-bit last_owner register (reset value IC).
  - When both are valid, the requester that was not last granted wins. last_owner updates on every accept.
  - Prevents IC starvation during DC writeback streams.
- MEM_ARB_RR_EN undefined: fixed DC-over-IC priority and no last_owner register.

Test Plan:
- IC read alone: ic_req_valid=1, addr=0x0000_1000; mem_req_ready=1; mem returns 0xDEAD..BEEF 3 cycles after issue.
  - Required: mem_req_addr=0x1000, mem_req_rw=0.
  - Required: ic_resp_valid is a single pulse with that data.
  - Required: dc_resp_valid stays 0 and busy drops the same cycle.
- DC write with backpressure: dc_req_rw=1, addr=0x2000, wdata=0x1234; mem_req_ready low for 4 cycles.
  - Required: mem_req_valid is held for 5 cycles with stable addr/wdata.
  - Required: dc_resp_valid pulses with data 0 one cycle after the handshake, and there is no WAIT_RESP.
- Simultaneous IC and DC reads held valid:
  - Default build: DC is granted first (dc_req_ready=1, ic_req_ready=0), then IC is granted after DC's response.
  - MEM_ARB_RR_EN build with last_owner=DC: IC is granted first.
- Spurious response: mem_resp_valid=1 while in IDLE.
  - Required: err=1 and stays 1, no resp_valid pulses, and the next transaction completes normally.
- Reset mid-read: reset_n low during WAIT_RESP.
  - Required: all outputs 0 immediately (asynchronous).
  - Required: after release, mem_resp_valid sets err and produces no ic_resp_valid or dc_resp_valid.
- Back-to-back: DC read response cycle coincides with a pending ic_req_valid.
  - Required: IC is accepted in the same cycle dc_resp_valid=1.
  - Required: mem_req_valid for IC is asserted the following cycle.
